// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder.
// The FSM state encoding and the counter-width helper live here.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
// The sub signal exists only when DSA_SUB_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef DSA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin,
`ifdef DSA_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef DSA_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the final digit.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_s[i]),
            .s  (s[i]),
            .co (c_s[i+1])
        );
    end

    assign co    = c_s[DIGIT];
    assign c_msb = c_s[DIGIT-1];
endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used to build the digit ripple chain.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder summing two WIDTH-bit operands DIGIT bits per clock.
// Define DSA_SUB_EN to add the sub port (a-b via ~b plus forced carry-in).
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic             in_ready_r;

    logic [DIGIT-1:0] dsum_s;
    logic             dco_s;
    logic             dcmsb_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] sum_next_s;
    logic             sub_s;

`ifdef DSA_SUB_EN
    assign sub_s = bus.sub;
`else
    assign sub_s = 1'b0;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_r[DIGIT-1:0]),
        .b     (b_r[DIGIT-1:0]),
        .ci    (carry_r),
        .s     (dsum_s),
        .co    (dco_s),
        .c_msb (dcmsb_s)
    );

    // Result digits enter at the MSB end so after N shifts the LSB digit sits at bit 0.
    if (WIDTH == DIGIT) begin : g_single
        assign a_next_s   = a_r;
        assign b_next_s   = b_r;
        assign sum_next_s = dsum_s;
    end else begin : g_multi
        assign a_next_s   = {{DIGIT{1'b0}}, a_r[WIDTH-1:DIGIT]};
        assign b_next_s   = {{DIGIT{1'b0}}, b_r[WIDTH-1:DIGIT]};
        assign sum_next_s = {dsum_s, sum_r[WIDTH-1:DIGIT]};
    end

    // Control FSM, operand/result shift registers and handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= sub_s ? ~bus.b : bus.b;
                        carry_r    <= sub_s ? 1'b1 : bus.cin;
                        count_r    <= CW'(N - 1);
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= a_next_s;
                    b_r     <= b_next_s;
                    sum_r   <= sum_next_s;
                    carry_r <= dco_s;
                    if (count_r == {CW{1'b0}}) begin
                        cout_r      <= dco_s;
                        ovf_r       <= dco_s ^ dcmsb_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        count_r <= count_r - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=8, DIGIT=2): random and directed
// operations checked against an integer-arithmetic reference model.
module tb_digit_serial_adder;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   acc_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub + int'(cin);
            sr     = sa + sb + int'(cin);
            e.cout = (r > 255);
        end
        e.sum = r[7:0];
        e.ovf = (sr > 127) || (sr < -128);
        return e;
    endfunction

    // Monitor: latency on out_valid rise, result compare while presented.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   acc;
        if (rst_n) begin
            if (bus.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    check("latency_unexpected", 1, 0);
                end else begin
                    acc = acc_q.pop_front();
                    check("latency", cyc - acc, N);
                end
            end
            if (bus.out_valid) begin
                check("in_ready_busy", int'(bus.in_ready), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("sum",  int'(bus.sum),  int'(e.sum));
                    check("cout", int'(bus.cout), int'(e.cout));
                    check("ovf",  int'(bus.ovf),  int'(e.ovf));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        input logic ts, input bit hold);
        bit ok;
        ok = 1'b0;
        bus.a        = ta;
        bus.b        = tb2;
        bus.cin      = tc;
`ifdef DSA_SUB_EN
        bus.sub      = ts;
`endif
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(ta, tb2, tc, ts));
                acc_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain(input bit rnd);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && bus.in_ready;
            bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        bus.out_ready = 1'b1;
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] ra, rb;
        logic       rc, rs;
        bit         seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.cin       = 1'b0;
`ifdef DSA_SUB_EN
        bus.sub       = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_sum",       int'(bus.sum),       0);
        check("rst_cout",      int'(bus.cout),      0);
        check("rst_ovf",       int'(bus.ovf),       0);
        check("rst_in_ready",  int'(bus.in_ready),  1);
        @(posedge clk); #1;

        // Directed arithmetic corners
        send(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0); drain(1'b0);
        @(negedge clk);
        check("idle_retain_sum", int'(bus.sum), 8'h8D);
        @(posedge clk); #1;
        send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); drain(1'b0);
        send(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0); drain(1'b0);
`ifdef DSA_SUB_EN
        send(8'h10, 8'h20, 1'b0, 1'b1, 1'b0); drain(1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b0); drain(1'b0);
        send(8'h80, 8'h01, 1'b1, 1'b1, 1'b0); drain(1'b0);
`endif

        // Backpressure: hold result while in_valid pulses are ignored
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        if (!seen) check("bp_valid_timeout", 0, 1);
        @(posedge clk); #1;
        bus.a = 8'hEE; bus.b = 8'hEE; bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain(1'b0);

        // Reset during the second RUN cycle abandons the operation
        send(8'hAB, 8'hCD, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_sum",       int'(bus.sum),       0);
        check("midrst_in_ready",  int'(bus.in_ready),  1);
        @(posedge clk); #1;
        send(8'h01, 8'h01, 1'b0, 1'b0, 1'b0); drain(1'b0);

        // Back-to-back with in_valid held high
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, 1'b0, 1'b1);
        end
        bus.in_valid = 1'b0;
        drain(1'b0);

        // Random operations with random consumer stalls
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
`ifdef DSA_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            send(ra, rb, rc, rs, 1'b0);
            drain(1'b1);
        end

        repeat (2) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
